// File: rtl/control_mascara.sv
// ============================================================================
// Module      : control_mascara
// Description : Coefficient-memory address generator for a convolution mask
//               engine. A two-entry register bank (DIM, BASE) sets up a
//               free-running sweep over base .. base+N*N-1.
//               Optional: CONTROL_MASCARA_FIN_EN adds the fin_mascara output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_mascara #(
    parameter int REG_ADDR_W = 11,
    parameter int REG_DATA_W = 21,
    parameter int MEM_ADDR_W = 10,
    parameter int DIM_W      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] direccion_registros,
    input  logic [REG_DATA_W-1:0] datos_registros,
    input  logic                  habilitacion_registros,
    output logic [MEM_ADDR_W-1:0] direccion_mem
`ifdef CONTROL_MASCARA_FIN_EN
    ,
    output logic                  fin_mascara
`endif
);

    localparam int IDX_W = 2 * DIM_W;

    localparam logic [REG_ADDR_W-1:0] c_ADDR_DIM  = REG_ADDR_W'(0);
    localparam logic [REG_ADDR_W-1:0] c_ADDR_BASE = REG_ADDR_W'(1);
    localparam logic [IDX_W-1:0]      c_IDX_ZERO  = '0;
    localparam logic [IDX_W-1:0]      c_IDX_ONE   = IDX_W'(1);

    logic [DIM_W-1:0]      r_dim;
    logic [MEM_ADDR_W-1:0] r_base;
    logic [IDX_W-1:0]      r_index;
    logic [MEM_ADDR_W-1:0] r_dir;

    logic                  w_wr_dim;
    logic                  w_wr_base;
    logic [IDX_W-1:0]      w_dim_sq;
    logic [IDX_W-1:0]      w_last;
    logic [IDX_W-1:0]      w_index_inc;
    logic [DIM_W-1:0]      w_dim_next;
    logic [MEM_ADDR_W-1:0] w_base_next;
    logic [IDX_W-1:0]      w_index_next;
    logic [MEM_ADDR_W-1:0] w_dir_next;
    logic                  w_unused_data;

    // Only the low DIM_W / MEM_ADDR_W data bits are architecturally meaningful.
    assign w_unused_data = ^datos_registros;

    assign w_wr_dim    = habilitacion_registros && (direccion_registros == c_ADDR_DIM);
    assign w_wr_base   = habilitacion_registros && (direccion_registros == c_ADDR_BASE);
    assign w_dim_sq    = {{DIM_W{1'b0}}, r_dim} * {{DIM_W{1'b0}}, r_dim};
    assign w_last      = w_dim_sq - c_IDX_ONE;
    assign w_index_inc = r_index + c_IDX_ONE;

    always_comb begin
        w_dim_next   = r_dim;
        w_base_next  = r_base;
        w_index_next = r_index;
        w_dir_next   = r_dir;

        if (w_wr_dim) begin
            w_dim_next = datos_registros[DIM_W-1:0];
        end
        if (w_wr_base) begin
            w_base_next = datos_registros[MEM_ADDR_W-1:0];
        end

        // Any register write restarts the sweep from the (possibly new) base.
        if (w_wr_dim || w_wr_base) begin
            w_index_next = c_IDX_ZERO;
            w_dir_next   = w_base_next;
        end else if (r_dim != '0) begin
            if (r_index == w_last) begin
                w_index_next = c_IDX_ZERO;
                w_dir_next   = r_base;
            end else begin
                w_index_next = w_index_inc;
                w_dir_next   = r_base + MEM_ADDR_W'(w_index_inc);
            end
        end else begin
            w_index_next = c_IDX_ZERO;
            w_dir_next   = r_base;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dim   <= '0;
            r_base  <= '0;
            r_index <= '0;
            r_dir   <= '0;
        end else begin
            r_dim   <= w_dim_next;
            r_base  <= w_base_next;
            r_index <= w_index_next;
            r_dir   <= w_dir_next;
        end
    end

    assign direccion_mem = r_dir;

`ifdef CONTROL_MASCARA_FIN_EN
    logic [IDX_W-1:0] w_dim_sq_next;
    logic             w_fin_next;
    logic             r_fin;

    // Flag is aligned with the address register: it marks the address being
    // loaded on this edge as the last coefficient of the sweep.
    assign w_dim_sq_next = {{DIM_W{1'b0}}, w_dim_next} * {{DIM_W{1'b0}}, w_dim_next};
    assign w_fin_next    = (w_dim_next != '0) &&
                           (w_index_next == (w_dim_sq_next - c_IDX_ONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fin <= 1'b0;
        end else begin
            r_fin <= w_fin_next;
        end
    end

    assign fin_mascara = r_fin;
`endif

endmodule

`default_nettype wire

// File: tb/tb_control_mascara.sv
// ============================================================================
// Module      : tb_control_mascara
// Description : Directed self-checking bench for control_mascara.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_mascara;

    logic        clk;
    logic        reset;
    logic [10:0] direccion_registros;
    logic [20:0] datos_registros;
    logic        habilitacion_registros;
    logic [9:0]  direccion_mem;
`ifdef CONTROL_MASCARA_FIN_EN
    logic        fin_mascara;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    control_mascara #(
        .REG_ADDR_W(11),
        .REG_DATA_W(21),
        .MEM_ADDR_W(10),
        .DIM_W     (5)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .direccion_registros   (direccion_registros),
        .datos_registros       (datos_registros),
        .habilitacion_registros(habilitacion_registros),
        .direccion_mem         (direccion_mem)
`ifdef CONTROL_MASCARA_FIN_EN
        ,
        .fin_mascara           (fin_mascara)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Address check plus the end-of-sweep flag when that output exists.
    task automatic chk_pos(input string tag, input int exp_addr, input bit exp_fin);
        check(tag, 32'(direccion_mem), 32'(exp_addr));
`ifdef CONTROL_MASCARA_FIN_EN
        check({tag, "_fin"}, 32'(fin_mascara), 32'(exp_fin));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [10:0] addr, input logic [20:0] data);
        direccion_registros    = addr;
        datos_registros        = data;
        habilitacion_registros = 1'b1;
        tick();
        habilitacion_registros = 1'b0;
        direccion_registros    = 11'($urandom);
        datos_registros        = 21'($urandom);
    endtask

    initial begin
        reset                  = 1'b1;
        habilitacion_registros = 1'b1;
        direccion_registros    = 11'($urandom_range(0, 1));
        datos_registros        = 21'($urandom);
        #2;

        // Reset wins over a simultaneous write.
        tick();
        reset                  = 1'b0;
        habilitacion_registros = 1'b0;
        chk_pos("reset", 0, 1'b0);
        tick();
        chk_pos("idle0", 0, 1'b0);
        tick();
        chk_pos("idle1", 0, 1'b0);

        // dim=3, base=0: 0..8 repeating, flag at address 8
        reg_write(11'd0, 21'd3);
        chk_pos("dim3_start", 0, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            tick();
            chk_pos($sformatf("dim3_seq%0d", i), i % 9, (i % 9) == 8);
        end

        // base=10: restart
        reg_write(11'd1, 21'd10);
        chk_pos("base10_start", 10, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_pos($sformatf("base10_seq%0d", i), 10 + i, 1'b0);
        end

        // Unmapped address write: sweep continues
        reg_write(11'd5, 21'd7);
        chk_pos("ignored_wr", 15, 1'b0);
        tick();
        chk_pos("ignored_16", 16, 1'b0);
        tick();
        chk_pos("ignored_17", 17, 1'b0);
        tick();
        chk_pos("ignored_18", 18, 1'b1);
        tick();
        chk_pos("wrap_10", 10, 1'b0);

        // DIM write with junk upper bits (0x23 -> dim 3): restart at base
        reg_write(11'd0, 21'h23);
        chk_pos("dim_upper_ign", 10, 1'b0);
        tick();
        chk_pos("dim_upper_11", 11, 1'b0);

        // base=1020 (upper data bit set, ignored): modulo-1024 wrap
        reg_write(11'd1, 21'h1003FC);
        chk_pos("b1020_0", 1020, 1'b0);
        tick(); chk_pos("b1020_1", 1021, 1'b0);
        tick(); chk_pos("b1020_2", 1022, 1'b0);
        tick(); chk_pos("b1020_3", 1023, 1'b0);
        tick(); chk_pos("b1020_4", 0, 1'b0);
        tick(); chk_pos("b1020_5", 1, 1'b0);
        tick(); chk_pos("b1020_6", 2, 1'b0);
        tick(); chk_pos("b1020_7", 3, 1'b0);
        tick(); chk_pos("b1020_8", 4, 1'b1);
        tick(); chk_pos("b1020_9", 1020, 1'b0);

        // dim=1: address stuck at base, flag always set
        reg_write(11'd0, 21'd1);
        chk_pos("dim1_0", 1020, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_pos($sformatf("dim1_%0d", i), 1020, 1'b1);
        end

        // dim=0: idle at base
        reg_write(11'd0, 21'd0);
        chk_pos("dim0_0", 1020, 1'b0);
        tick();
        chk_pos("dim0_1", 1020, 1'b0);
        reg_write(11'd1, 21'd5);
        chk_pos("dim0_base5", 5, 1'b0);
        tick();
        chk_pos("dim0_hold5", 5, 1'b0);

        // dim=2, base=5: 5,6,7,8,5
        reg_write(11'd0, 21'd2);
        chk_pos("dim2_0", 5, 1'b0);
        tick(); chk_pos("dim2_1", 6, 1'b0);
        tick(); chk_pos("dim2_2", 7, 1'b0);
        tick(); chk_pos("dim2_3", 8, 1'b1);
        tick(); chk_pos("dim2_4", 5, 1'b0);

        // Reset mid-sweep returns to idle at 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_pos("rst_mid", 0, 1'b0);
        tick();
        chk_pos("rst_idle0", 0, 1'b0);
        tick();
        chk_pos("rst_idle1", 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_mascara.md
Name: control_mascara

Overview:
- Address generator for the coefficient memory of a convolution mask (filter) engine.
- A small register bank, written through a simple address/data/enable port, holds the mask dimension N and the mask base address.
- The block continuously sweeps the memory address over the N*N coefficients starting at the base, one address per clock, so the downstream memory streams mask coefficients to the filter datapath.

Parameters:
- REG_ADDR_W, 11, width of register-bank address port.
- REG_DATA_W, 21, width of register-bank data port.
- MEM_ADDR_W, 10, width of coefficient memory address.
- DIM_W, 5, width of mask dimension register (max N = 2^DIM_W - 1 = 31).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- direccion_registros  in  REG_ADDR_W  register-bank write address.
- datos_registros  in  REG_DATA_W  register-bank write data.
- habilitacion_registros  in  1  write enable, one write per cycle when high.
- direccion_mem  out  MEM_ADDR_W  registered coefficient memory address.

Interface: one clock (clk); reset is synchronous and active-high (reset).

Behaviour:
- Register map; writes occur on a rising edge with habilitacion_registros=1:
  - addr 0 = DIM: datos_registros[DIM_W-1:0] → dim. Upper data bits are ignored.
  - addr 1 = BASE: datos_registros[MEM_ADDR_W-1:0] → base.
  - Any other address: write ignored, no side effects, no restart.
- Internal state: dim (DIM_W), base (MEM_ADDR_W), index (2*DIM_W, counts 0..dim*dim-1), direccion_mem register.
- Reset (sync): dim=0, base=0, index=0, direccion_mem=0. Reset has priority over a simultaneous write.
- Restart: a valid write to addr 0 or 1 at edge k sets index=0 and direccion_mem=base_new at edge k.
  - base_new is the written value for an addr-1 write, otherwise the current base.
  - A write has priority over counting.
- Counting, when there is no write and dim≠0, on each edge:
  - If index == dim*dim-1: index←0, direccion_mem←base (wrap).
  - Else: index←index+1, direccion_mem←base+index+1.
- dim=0: idle; index held at 0, direccion_mem held at base.
- dim=1: direccion_mem stays at base every cycle.
- Address arithmetic is modulo 2^MEM_ADDR_W: base+index wraps past 1023 to 0.
- dim*dim is computed combinationally from dim; no divider.
- No handshake or back-pressure; the sweep is free-running.
- Latency: direccion_mem shows the new base on the first edge after the enable is sampled, i.e. visible in the cycle following the write.

Optional Feature:
- Macro: CONTROL_MASCARA_FIN_EN.
- Defined: adds output port fin_mascara (out, 1 bit, registered, reset 0).
  - fin_mascara=1 in exactly the cycles where direccion_mem holds base+dim*dim-1 (last coefficient of the sweep), 0 otherwise.
  - It is 0 while dim=0.
  - For dim=1 it is constantly 1 after configuration.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: hold reset 1 cycle with random write inputs → direccion_mem=0 on the next edge; dim=0 so direccion_mem stays 0.
- Write addr0 data=3 (single-cycle enable) → direccion_mem sequence 0,1,2,…,8,0,1,… from the edge after the write; period 9.
- Then write addr1 data=10 → sweep restarts: 10,11,…,18,10,…; dim still 3.
- Write addr5 data=7 mid-sweep → ignored; sequence continues without restart.
- Write addr1 data=1020 with dim=3 → 1020,1021,1022,1023,0,1,2,3,4,1020 (mod-1024 wrap).
- Write addr0 data=0 → direccion_mem held at base; apply reset during an active sweep → direccion_mem=0 next edge and the block is idle. With CONTROL_MASCARA_FIN_EN defined, fin_mascara pulses high when direccion_mem=8 (base 0, dim 3).
